// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported dmem: IDLE grant, one ACCESS cycle, RESP done pulse.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_we;
    logic              r_owner;
    logic              r_mis;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic              w_pick1;
    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_mis;
    logic              w_rd_capture;

`ifdef DMEM_ARB_RR_EN
    logic r_last_owner;
    // On a tie the port that did not win last time goes next.
    assign w_pick1 = p1_req & (~p0_req | ~r_last_owner);
`else
    assign w_pick1 = p1_req & ~p0_req;
`endif

    assign w_grant      = (r_state == S_IDLE) & (p0_req | p1_req) & ~rst;
    assign w_sel_we     = w_pick1 ? p1_we    : p0_we;
    assign w_sel_addr   = w_pick1 ? p1_addr  : p0_addr;
    assign w_sel_wdata  = w_pick1 ? p1_wdata : p0_wdata;
    assign w_sel_mis    = (w_sel_addr[1:0] != 2'b00);
    assign w_rd_capture = (r_state == S_ACCESS) & ~r_we & ~r_mis & ~rst;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    p0_gnt = ~w_pick1;
                    p1_gnt = w_pick1;
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_read  = ~r_we & ~r_mis;
                mem_write = r_we & ~r_mis;
                w_next    = S_RESP;
            end
            S_RESP: begin
                p0_done = ~r_owner;
                p1_done = r_owner;
                p0_err  = ~r_owner & r_mis;
                p1_err  = r_owner & r_mis;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Reset kills any in-flight access immediately, including its write strobe.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            p0_done   = 1'b0;
            p1_done   = 1'b0;
            p0_err    = 1'b0;
            p1_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_owner     <= 1'b0;
            r_mis       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_we    <= w_sel_we;
                r_owner <= w_pick1;
                r_mis   <= w_sel_mis;
                // Misaligned requests never reach dmem, so the bus keeps its old values.
                if (!w_sel_mis) begin
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_wdata;
                end
            end
            if (w_rd_capture) begin
                if (r_owner) begin
                    r_p1_rdata <= mem_rdata;
                end else begin
                    r_p0_rdata <= mem_rdata;
                end
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= 1'b1;
        end else if (w_grant) begin
            r_last_owner <= w_pick1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-port expected-response queues checked by a done monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // dmem model: combinational read, write at the closing edge.
    logic [31:0] mem [16];
    logic        mem_init;
    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h11111111;
            mem[1] <= 32'h22222222;
            mem[3] <= 32'h0C0C0C0C;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   gnt_port[$];
    int   gnt_cyc[$];
    int   last_gnt[2];
    int   wr_cnt = 0;
    int   done_cnt[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic on_done(input int p, input logic err, input logic [31:0] rdata);
        exp_t e;
        done_cnt[p]++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_done_p%0d", p), 32'd1, 32'd0);
        end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("err_p%0d", p), {31'd0, err}, {31'd0, e.err});
            if (e.chk) check($sformatf("rdata_p%0d", p), rdata, e.rdata);
            check($sformatf("done_latency_p%0d", p), cyc - last_gnt[p], 32'd2);
        end
    endtask

    always @(negedge clk) begin
        if (p0_gnt && p1_gnt) check("dual_gnt", 32'd1, 32'd0);
        if (p0_gnt) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); last_gnt[0] = cyc; end
        if (p1_gnt) begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); last_gnt[1] = cyc; end
        if (mem_write) wr_cnt++;
        if (p0_done) on_done(0, p0_err, p0_rdata);
        if (p1_done) on_done(1, p1_err, p1_rdata);
    end

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic chk, input logic [31:0] exp_rd);
        exp_t e;
        logic got;
        e.err = exp_err; e.chk = chk; e.rdata = exp_rd;
        if (p == 0) begin
            q0.push_back(e); p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd;
        end else begin
            q1.push_back(e); p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? p0_gnt : p1_gnt;
        end
        if (!got) check($sformatf("gnt_timeout_p%0d", p), 32'd0, 32'd1);
        @(posedge clk); #1;
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("drain_q0", q0.size(), 32'd0);
        check("drain_q1", q1.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int rel, base, w0, d0, d1;
        int exp_ports[4];
        logic got;
`ifdef DMEM_ARB_RR_EN
        exp_ports = '{0, 1, 0, 0};
`else
        exp_ports = '{0, 0, 0, 1};
`endif
        done_cnt[0] = 0; done_cnt[1] = 0; last_gnt[0] = 0; last_gnt[1] = 0;
        rst = 1'b1; mem_init = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4; p1_wdata = 32'h0;
        @(posedge clk); #1; mem_init = 1'b0;

        // Reset values with both requests pending.
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
            check("rst_done_err", {28'd0, p1_done, p0_done, p1_err, p0_err}, 32'd0);
            check("rst_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
            check("rst_p0_rdata", p0_rdata, 32'd0);
            check("rst_p1_rdata", p1_rdata, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; rel = cyc;

        // First tie goes to p0; p0_rdata must survive p1's later read.
        fork
            issue(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111);
            issue(1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'h22222222);
        join
        drain();
        check("first_gnt_port", gnt_port[0], 32'd0);
        check("first_gnt_cycle", gnt_cyc[0], rel);
        check("second_gnt_port", gnt_port[1], 32'd1);
        check("hold_p0_rdata", p0_rdata, 32'h11111111);
        check("hold_p1_rdata", p1_rdata, 32'h22222222);

        // Continuous contention: p0 reads three times while p1 waits to write.
        base = gnt_port.size();
        fork
            repeat (3) issue(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111);
            issue(1, 1'b1, 32'h8, 32'h12345678, 1'b0, 1'b0, 32'h0);
        join
        drain();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("contend_port%0d", k), gnt_port[base + k], exp_ports[k]);
            check($sformatf("contend_gap%0d", k), gnt_cyc[base + k] - gnt_cyc[base], 3 * k);
        end
        check("contend_mem8", mem[2], 32'h12345678);

        // Write then read the same word back-to-back.
        base = gnt_port.size(); w0 = wr_cnt; d1 = done_cnt[1];
        issue(0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        issue(0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        drain();
        check("wr_cycles", wr_cnt - w0, 32'd1);
        check("wr_rd_gap", gnt_cyc[base + 1] - gnt_cyc[base], 32'd3);
        check("no_p1_done", done_cnt[1] - d1, 32'd0);

        // Misaligned write suppressed; misaligned read keeps old rdata.
        w0 = wr_cnt;
        issue(1, 1'b1, 32'h6, 32'hAAAAAAAA, 1'b1, 1'b0, 32'h0);
        drain();
        check("mis_no_write", wr_cnt - w0, 32'd0);
        issue(1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h2, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        drain();

        // Reset during the ACCESS cycle of a write.
        w0 = wr_cnt; d0 = done_cnt[0]; d1 = done_cnt[1];
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'hC; p0_wdata = 32'h55555555;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = p0_gnt;
        end
        check("rstmid_gnt", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstmid_mem_write", {31'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_no_done", (done_cnt[0] - d0) + (done_cnt[1] - d1), 32'd0);
        check("rstmid_no_write", wr_cnt - w0, 32'd0);
        @(posedge clk); #1;
        issue(0, 1'b0, 32'hC, 32'h0, 1'b0, 1'b1, 32'h0C0C0C0C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
